// File: rtl/lutnet_pkg.sv
// Shared constants and FSM state type for the time-multiplexed LUT neuron scheduler.
package lutnet_pkg;

    localparam int FANIN   = 6;
    localparam int TABLE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lut6_eval.sv
// Combinational 6-input LUT: selects one truth-table bit by a 6-bit address.
module lut6_eval
    import lutnet_pkg::*;
(
    input  logic [TABLE_W-1:0] lut_bits,
    input  logic [FANIN-1:0]   addr,
    output logic               y
);

    always_comb y = lut_bits[addr];

endmodule

// File: rtl/lut_neuron_sched.sv
// Evaluates NUM_NEURONS 6-input LUT neurons one per cycle on a shared evaluator,
// with a flop-based configuration store writable only while idle.
module lut_neuron_sched
    import lutnet_pkg::*;
#(
    parameter int NUM_IN      = 16,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = $clog2(NUM_IN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_IN-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_NEURONS-1:0]         out_data,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_NEURONS)-1:0] cfg_neuron,
    input  logic [TABLE_W-1:0]             cfg_table,
    input  logic [FANIN*IDX_W-1:0]         cfg_idx,
    output logic                           cfg_err,
    output logic                           busy
);

    localparam int NW = $clog2(NUM_NEURONS);
    localparam int IW = FANIN * IDX_W;
    localparam logic [NW-1:0] LAST = NW'(NUM_NEURONS - 1);

    state_t                 state;
    logic [NW-1:0]          n;
    logic                   last;
    logic [NUM_IN-1:0]      in_reg;
    logic [NUM_NEURONS-1:0] acc;
    logic [NUM_NEURONS-1:0] res;
    logic [TABLE_W-1:0]     tbl_q [NUM_NEURONS];
    logic [IW-1:0]          idx_q [NUM_NEURONS];
    logic [FANIN-1:0]       addr;
    logic [IDX_W-1:0]       fidx;
    logic                   lut_y;
    logic                   cfg_ok;

    always_comb begin
        addr = '0;
        fidx = '0;
        for (int unsigned k = 0; k < FANIN; k++) begin
            fidx    = idx_q[n][k*IDX_W +: IDX_W];
            addr[k] = (int'(fidx) < NUM_IN) ? in_reg[fidx] : 1'b0;
        end
    end

    lut6_eval u_eval (
        .lut_bits (tbl_q[n]),
        .addr     (addr),
        .y        (lut_y)
    );

    always_comb cfg_ok   = (state == ST_IDLE) && (int'(cfg_neuron) < NUM_NEURONS);
    always_comb out_data = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                tbl_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                tbl_q[cfg_neuron] <= cfg_table;
                idx_q[cfg_neuron] <= cfg_idx;
            end
        end
    end

    // Results accumulate in acc and are published to res on a final cycle, so
    // out_data never exposes a partially evaluated vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            n         <= '0;
            last      <= 1'b0;
            in_reg    <= '0;
            acc       <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_reg   <= in_data;
                        n        <= '0;
                        last     <= 1'b0;
                        state    <= ST_EVAL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (last) begin
                        res       <= acc;
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        acc[n] <= lut_y;
                        if (n == LAST) last <= 1'b1;
                        else           n    <= n + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_neuron_sched.sv
// Directed self-checking bench for lut_neuron_sched (8-neuron instance plus a
// 6-neuron, 10-input instance for out-of-range index and neuron cases).
module tb_lut_neuron_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data;
    logic [7:0]  out_data;
    logic        cfg_we, cfg_err, busy;
    logic [2:0]  cfg_neuron;
    logic [63:0] cfg_table;
    logic [23:0] cfg_idx;

    logic        s6_in_valid, s6_in_ready, s6_out_valid, s6_out_ready;
    logic [9:0]  s6_in_data;
    logic [5:0]  s6_out_data;
    logic        s6_cfg_we, s6_cfg_err, s6_busy;
    logic [2:0]  s6_cfg_neuron;
    logic [63:0] s6_cfg_table;
    logic [23:0] s6_cfg_idx;

    int errors = 0;
    int checks = 0;

    lut_neuron_sched #(.NUM_IN(16), .NUM_NEURONS(8), .IDX_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_table(cfg_table),
        .cfg_idx(cfg_idx), .cfg_err(cfg_err), .busy(busy)
    );

    lut_neuron_sched #(.NUM_IN(10), .NUM_NEURONS(6), .IDX_W(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s6_in_valid), .in_ready(s6_in_ready), .in_data(s6_in_data),
        .out_valid(s6_out_valid), .out_ready(s6_out_ready), .out_data(s6_out_data),
        .cfg_we(s6_cfg_we), .cfg_neuron(s6_cfg_neuron), .cfg_table(s6_cfg_table),
        .cfg_idx(s6_cfg_idx), .cfg_err(s6_cfg_err), .busy(s6_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] nrn, input logic [63:0] tbl, input logic [23:0] idx);
        cfg_neuron = nrn;
        cfg_table  = tbl;
        cfg_idx    = idx;
        cfg_we     = 1'b1;
        tick(1);
        cfg_we     = 1'b0;
    endtask

    // Accept edge, 8 evaluation edges, then out_valid on the 9th edge.
    task automatic transact(input logic [15:0] d, input logic [7:0] exp, input string tag);
        in_data  = d;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check(cfg_err, 0, {tag, "_cfg_err"});
        check(in_ready, 0, {tag, "_in_ready_busy"});
        tick(8);
        check(out_valid, 0, {tag, "_valid_early"});
        tick(1);
        check(out_valid, 1, {tag, "_valid"});
        check(out_data, exp, {tag, "_data"});
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check(in_ready, 1, {tag, "_back_idle"});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_neuron = '0; cfg_table = '0; cfg_idx = '0;
        s6_in_valid = 1'b0; s6_in_data = '0; s6_out_ready = 1'b0;
        s6_cfg_we = 1'b0; s6_cfg_neuron = '0; s6_cfg_table = '0; s6_cfg_idx = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check(in_ready, 1, "rst_in_ready");
        check(out_valid, 0, "rst_out_valid");
        check(out_data, 0, "rst_out_data");
        check(busy, 0, "rst_busy");
        check(cfg_err, 0, "rst_cfg_err");

        // Neuron i copies in_data[i]: table bit a = a[0], field 0 = i.
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 64'hAAAA_AAAA_AAAA_AAAA, 24'(i));
        check(cfg_err, 0, "cfg_ok_no_err");
        in_data = 16'h00A5; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        check(busy, 1, "eval_busy");
        tick(8);
        check(out_valid, 0, "lat_edge8");
        check(out_data, 0, "eval_shows_prev");
        tick(1);
        check(out_valid, 1, "lat_edge9");
        check(out_data, 8'hA5, "copy_a5");

        for (int c = 0; c < 20; c++) begin
            tick(1);
            check(out_data, 8'hA5, "hold_data");
            check(in_ready, 0, "hold_in_ready");
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check(in_ready, 1, "release_idle");
        check(out_valid, 0, "release_valid");
        check(out_data, 8'hA5, "idle_keeps_last");

        // Config write on the accept edge applies to the captured vector.
        cfg_neuron = 3'd0; cfg_table = 64'h8000_0000_0000_0000; cfg_idx = 24'h543210;
        cfg_we = 1'b1;
        transact(16'h003F, 8'h3F, "and6_hit");
        transact(16'h003E, 8'h3E, "and6_miss");

        // Write attempt during EVAL is rejected; old config still used.
        in_data = 16'h003F; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        cfg_neuron = 3'd0; cfg_table = '0; cfg_idx = '0; cfg_we = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        check(cfg_err, 1, "busy_cfg_err");
        tick(1);
        check(cfg_err, 0, "busy_cfg_err_1cyc");
        tick(5);
        check(out_valid, 0, "busy_cfg_lat");
        tick(1);
        check(out_data, 8'h3F, "busy_cfg_old");
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        transact(16'h003F, 8'h3F, "cfg_kept");

        // 6-neuron, 10-input instance: index >= NUM_IN reads 0.
        s6_cfg_neuron = 3'd0; s6_cfg_table = 64'hAAAA_AAAA_AAAA_AAAA; s6_cfg_idx = 24'h00000C;
        s6_cfg_we = 1'b1;
        tick(1);
        check(s6_cfg_err, 0, "s6_cfg_ok");
        s6_cfg_neuron = 3'd1; s6_cfg_table = 64'h5555_5555_5555_5555; s6_cfg_idx = 24'h00000F;
        tick(1);
        s6_cfg_neuron = 3'd7; s6_cfg_table = 64'hFFFF_FFFF_FFFF_FFFF; s6_cfg_idx = '0;
        tick(1);
        s6_cfg_we = 1'b0;
        check(s6_cfg_err, 1, "s6_bad_neuron_err");
        tick(1);
        check(s6_cfg_err, 0, "s6_bad_neuron_1cyc");
        s6_in_data = 10'h3FF; s6_in_valid = 1'b1;
        tick(1);
        s6_in_valid = 1'b0;
        tick(6);
        check(s6_out_valid, 0, "s6_lat_early");
        tick(1);
        check(s6_out_valid, 1, "s6_valid");
        check(s6_out_data, 6'h02, "s6_idx_oob_zero");
        s6_out_ready = 1'b1;
        tick(1);
        s6_out_ready = 1'b0;

        // Reset at n=3 aborts with no output.
        in_data = 16'h00FF; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        check(out_valid, 0, "abort_valid");
        check(out_data, 0, "abort_data");
        check(in_ready, 1, "abort_in_ready");
        check(busy, 0, "abort_busy");
        tick(1);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            check(out_valid, 0, "abort_no_valid");
        end
        transact(16'hFFFF, 8'h00, "cfg_cleared");
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 64'hAAAA_AAAA_AAAA_AAAA, 24'(i + 8));
        transact(16'h5A00, 8'h5A, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
